// File: rtl/code_2421_stream_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : code_2421_stream_checker_pkg
// Description : Shared definitions for the 2421 stream checker and decoder.
//               - 2421 code words for decimal digits 0..9
//               - checker FSM state encoding
//               - decimal successor helper
// Revision    : 1.0 - initial release
// ============================================================================
package code_2421_stream_checker_pkg;

  // 2421 code words. The middle six patterns (0101..1010) are not used.
  localparam logic [3:0] C2421_0 = 4'b0000;
  localparam logic [3:0] C2421_1 = 4'b0001;
  localparam logic [3:0] C2421_2 = 4'b0010;
  localparam logic [3:0] C2421_3 = 4'b0011;
  localparam logic [3:0] C2421_4 = 4'b0100;
  localparam logic [3:0] C2421_5 = 4'b1011;
  localparam logic [3:0] C2421_6 = 4'b1100;
  localparam logic [3:0] C2421_7 = 4'b1101;
  localparam logic [3:0] C2421_8 = 4'b1110;
  localparam logic [3:0] C2421_9 = 4'b1111;

  // Checker FSM states.
  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  // Decimal successor: 9 rolls over to 0.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage : code_2421_stream_checker_pkg
`default_nettype wire

// File: rtl/code_2421_decode.sv
`default_nettype none
// ============================================================================
// Module      : code_2421_decode
// Description : Combinational 2421 -> 8421 digit decoder with legality flag.
// Ports       : code_i  [3:0]  2421-coded digit
//               bin_o   [3:0]  binary digit 0..9 (0 when illegal)
//               legal_o        high when code_i is one of the ten code words
// Revision    : 1.0 - initial release
// ============================================================================
module code_2421_decode (
  input  logic [3:0] code_i,
  output logic [3:0] bin_o,
  output logic       legal_o
);
  import code_2421_stream_checker_pkg::*;

  always_comb begin
    bin_o   = 4'd0;
    legal_o = 1'b1;
    case (code_i)
      C2421_0: bin_o = 4'd0;
      C2421_1: bin_o = 4'd1;
      C2421_2: bin_o = 4'd2;
      C2421_3: bin_o = 4'd3;
      C2421_4: bin_o = 4'd4;
      C2421_5: bin_o = 4'd5;
      C2421_6: bin_o = 4'd6;
      C2421_7: bin_o = 4'd7;
      C2421_8: bin_o = 4'd8;
      C2421_9: bin_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule : code_2421_decode
`default_nettype wire

// File: rtl/code_2421_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : code_2421_stream_checker
// Description : Receive-side checker for a 2421-coded decimal counter stream.
//               Decodes each valid sample, flags illegal code words and
//               out-of-sequence digits, locks after LOCK_N consecutive
//               in-sequence samples, and counts decade wraps and errors.
// Ports       : x            clock (posedge)
//               reset        asynchronous active-high reset
//               in_valid     code carries a sample this cycle
//               code [3:0]   2421-coded digit
//               digit [3:0]  last decoded digit (registered)
//               digit_valid  pulse: digit loaded from a legal sample
//               code_err     pulse: sample was not a legal 2421 word
//               seq_err      pulse: legal but non-successor sample while locked
//               locked       high while in the LOCKED state
//               wrap_count   9->0 transitions seen while locked (modulo)
//               err_count    code_err + seq_err events (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module code_2421_stream_checker #(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              x,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        code,
  output logic [3:0]        digit,
  output logic              digit_valid,
  output logic              code_err,
  output logic              seq_err,
  output logic              locked,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count
);
  import code_2421_stream_checker_pkg::*;

  localparam logic [3:0] C_LOCK_N = 4'(LOCK_N);

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [3:0] dec_bin;
  logic       dec_legal;

  code_2421_decode u_decode (
    .code_i  (code),
    .bin_o   (dec_bin),
    .legal_o (dec_legal)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic [3:0]        digit_q;
  logic              digit_valid_q;
  logic              code_err_q;
  logic              seq_err_q;
  logic [3:0]        good_run_q;
  logic              have_ref_q;   // digit_q holds a reference for the successor test
  logic [WRAP_W-1:0] wrap_count_q;
  logic [ERR_W-1:0]  err_count_q;

  // Next-value helpers
  logic              is_succ;
  logic [3:0]        good_run_d;
  logic [WRAP_W-1:0] wrap_count_d;
  logic [ERR_W-1:0]  err_count_d;

  assign is_succ      = (dec_bin == next_digit(digit_q));
  assign good_run_d   = good_run_q + 4'd1;
  assign wrap_count_d = wrap_count_q + WRAP_W'(1);
  // Saturate at all-ones; error pulses still fire when the count is stuck.
  assign err_count_d  = (err_count_q == {ERR_W{1'b1}}) ? err_count_q
                                                       : err_count_q + ERR_W'(1);

  always_ff @(posedge x or posedge reset) begin
    if (reset) begin
      state_q       <= ST_UNLOCKED;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      good_run_q    <= 4'd0;
      have_ref_q    <= 1'b0;
      wrap_count_q  <= '0;
      err_count_q   <= '0;
    end else begin
      // Pulses default low; state and digit hold when no sample arrives.
      digit_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      seq_err_q     <= 1'b0;

      if (in_valid) begin
        if (!dec_legal) begin
          // Illegal word: digit held, sequence reference discarded.
          code_err_q  <= 1'b1;
          state_q     <= ST_UNLOCKED;
          good_run_q  <= 4'd0;
          have_ref_q  <= 1'b0;
          err_count_q <= err_count_d;
        end else begin
          digit_q       <= dec_bin;
          digit_valid_q <= 1'b1;
          have_ref_q    <= 1'b1;

          if (state_q == ST_LOCKED) begin
            if (is_succ) begin
              // Successor of 9 is 0: one full decade completed.
              if (dec_bin == 4'd0) begin
                wrap_count_q <= wrap_count_d;
              end
            end else begin
              seq_err_q   <= 1'b1;
              err_count_q <= err_count_d;
              state_q     <= ST_UNLOCKED;
              good_run_q  <= 4'd0;
            end
          end else begin
            if (!have_ref_q) begin
              // First sample after reset or an illegal word only seeds digit.
              good_run_q <= 4'd0;
            end else if (is_succ) begin
              if (good_run_d >= C_LOCK_N) begin
                state_q    <= ST_LOCKED;
                good_run_q <= 4'd0;
              end else begin
                good_run_q <= good_run_d;
              end
            end else begin
              // Out of sequence while hunting: restart the run silently.
              good_run_q <= 4'd0;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign code_err    = code_err_q;
  assign seq_err     = seq_err_q;
  assign locked      = (state_q == ST_LOCKED);
  assign wrap_count  = wrap_count_q;
  assign err_count   = err_count_q;

endmodule : code_2421_stream_checker
`default_nettype wire
